// File: rtl/button_pkg.sv
// Shared state encoding and default timing constants for the button event decoder.
package button_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 1_000_000;
    localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t RELEASED = 2'd0;
    localparam btn_state_t HELD     = 2'd1;
    localparam btn_state_t LONG     = 2'd2;

endpackage

// File: rtl/level_filter.sv
// Debounce filter: the output level flips only after STABLE_CYCLES consecutive
// disagreeing samples; toggle_c flags the edge on which that flip is captured.
module level_filter
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic level_in,
    output logic level_out,
    output logic toggle_c
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] run_cnt;

    // The current sample is the last one needed when the run already holds STABLE_CYCLES-1.
    always_comb begin
        toggle_c = (level_in != level_out) && (run_cnt == CNT_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_out <= 1'b0;
            run_cnt   <= '0;
        end else if (toggle_c) begin
            level_out <= ~level_out;
            run_cnt   <= '0;
        end else if (level_in == level_out) begin
            run_cnt   <= '0;
        end else begin
            run_cnt   <= run_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Debounced button with press/release/long-press/auto-repeat pulses.
// release is a reserved word, so that output is named release_pulse.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic button_level,
    input  logic repeat_en,
    output logic button_state,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic toggle_c;
    logic rise_c;
    logic fall_c;

    btn_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_nxt;
    logic              press_nxt, release_nxt, long_nxt, repeat_nxt;

    level_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_level_filter (
        .clock     (clock),
        .reset     (reset),
        .level_in  (button_level),
        .level_out (button_state),
        .toggle_c  (toggle_c)
    );

    // Qualify the filter flip with the level it is leaving so events land with the new level.
    always_comb begin
        rise_c = toggle_c & ~button_state;
        fall_c = toggle_c &  button_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RELEASED;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            rep_cnt       <= rep_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    // Next state, counters and event pulses; a falling level wins over every hold event.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rep_nxt     = rep_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;

        case (state)
            RELEASED: begin
                if (rise_c) begin
                    state_nxt = HELD;
                    hold_nxt  = HOLD_W'(1);
                    rep_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            HELD: begin
                if (fall_c) begin
                    state_nxt   = RELEASED;
                    hold_nxt    = '0;
                    rep_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = LONG;
                    hold_nxt  = HOLD_MAX;
                    rep_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                // Hold counter stays saturated at LONG_CYCLES here.
                if (fall_c) begin
                    state_nxt   = RELEASED;
                    hold_nxt    = '0;
                    rep_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (!repeat_en) begin
                    rep_nxt    = '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_nxt    = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    rep_nxt    = rep_cnt + REP_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                hold_nxt  = '0;
                rep_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scenario bench for button_event_decoder with STABLE=4, LONG=10, REPEAT=3.
module tb_button_event_decoder;

    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned LONG_CYCLES   = 10;
    localparam int unsigned REPEAT_CYCLES = 3;

    // Output vector order: {button_state, press, release, long_press, repeat_pulse}
    localparam logic [4:0] E_IDLE  = 5'b00000;
    localparam logic [4:0] E_HIGH  = 5'b10000;
    localparam logic [4:0] E_PRESS = 5'b11000;
    localparam logic [4:0] E_REL   = 5'b00100;
    localparam logic [4:0] E_LONG  = 5'b10010;
    localparam logic [4:0] E_REP   = 5'b10001;

    logic clock;
    logic reset;
    logic button_level;
    logic repeat_en;
    logic button_state;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];

    button_event_decoder #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .LONG_CYCLES   (LONG_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .button_level  (button_level),
        .repeat_en     (repeat_en),
        .button_state  (button_state),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, compare after the edge.
    task automatic step(input logic lvl, input logic ren, input logic rst,
                        input logic [4:0] exp, input string tag);
        logic [4:0] got;
        logic [4:0] want;
        button_level = lvl;
        repeat_en    = ren;
        reset        = rst;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        got  = {button_state, press, release_pulse, long_press, repeat_pulse};
        want = exp_q.pop_front();
        check_eq(tag, got, want);
    endtask

    task automatic press_seq(input logic ren, input string tag);
        for (int i = 1; i <= 3; i++) step(1'b1, ren, 1'b0, E_IDLE, tag);
        step(1'b1, ren, 1'b0, E_PRESS, tag);
    endtask

    initial begin
        logic [4:0] e;
        button_level = 1'b0;
        repeat_en    = 1'b0;
        reset        = 1'b1;

        step(1'b0, 1'b0, 1'b1, E_IDLE, "reset");
        step(1'b1, 1'b1, 1'b1, E_IDLE, "reset_prio");

        // Short glitch never reaches the debounce threshold.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, E_IDLE, "glitch_hi");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, E_IDLE, "glitch_lo");

        // Clean press then long hold with auto-repeat.
        press_seq(1'b1, "clean_press");
        for (int k = 2; k <= 20; k++) begin
            e = E_HIGH;
            if (k == 10) e = E_LONG;
            else if (k == 13 || k == 16 || k == 19) e = E_REP;
            step(1'b1, 1'b1, 1'b0, e, "long_rep");
        end

        // Bouncy release: low 2, high 1, low 4.
        step(1'b0, 1'b0, 1'b0, E_HIGH, "rel_bounce");
        step(1'b0, 1'b0, 1'b0, E_HIGH, "rel_bounce");
        step(1'b1, 1'b0, 1'b0, E_HIGH, "rel_bounce");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, E_HIGH, "rel_bounce");
        step(1'b0, 1'b0, 1'b0, E_REL, "release");
        step(1'b0, 1'b1, 1'b0, E_IDLE, "after_rel");
        step(1'b0, 1'b1, 1'b0, E_IDLE, "after_rel");

        // Repeat disabled until held-cycle 15, then the period restarts.
        press_seq(1'b0, "press2");
        for (int k = 2; k <= 22; k++) begin
            e = E_HIGH;
            if (k == 10) e = E_LONG;
            else if (k == 18 || k == 21) e = E_REP;
            step(1'b1, (k >= 16), 1'b0, e, "rep_gate");
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, E_HIGH, "rel2");
        step(1'b0, 1'b0, 1'b0, E_REL, "release2");

        // Reset while in LONG with the level still high.
        press_seq(1'b0, "press3");
        for (int k = 2; k <= 12; k++) begin
            e = (k == 10) ? E_LONG : E_HIGH;
            step(1'b1, 1'b0, 1'b0, e, "hold3");
        end
        step(1'b1, 1'b0, 1'b1, E_IDLE, "reset_long");
        press_seq(1'b0, "repress");
        step(1'b1, 1'b0, 1'b0, E_HIGH, "repress_hold");
        step(1'b0, 1'b0, 1'b1, E_IDLE, "final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 1_000_000: consecutive disagreeing samples needed to accept a level change; legal range >=1.
REQ-002 Parameter LONG_CYCLES, default 50_000_000: cycles of debounced-high before long_press; legal range >=2.
REQ-003 Parameter REPEAT_CYCLES, default 10_000_000: auto-repeat period after long_press; legal range >=1.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 button_level  input  1  already-synchronized raw button level, still bouncing.
REQ-008 repeat_en  input  1  enables auto-repeat pulses after a long press.
REQ-009 button_state  output  1  debounced button level, registered.
REQ-010 press  output  1  one-cycle pulse on debounced rising transition.
REQ-011 release  output  1  one-cycle pulse on debounced falling transition.
REQ-012 long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-013 repeat_pulse  output  1  one-cycle periodic pulse during a long hold.

Function
REQ-014 Filter: counter clears on any cycle where button_level equals button_state; otherwise it increments.
REQ-015 button_state SHALL toggle on the edge capturing the STABLE_CYCLES-th consecutive disagreeing sample; counter clears on that edge.
REQ-016 A disagreement run shorter than STABLE_CYCLES SHALL leave button_state unchanged and produce no event.
REQ-017 Event FSM states: RELEASED, HELD, LONG; reset state RELEASED.
REQ-018 RELEASED->HELD when button_state rises; press high exactly in the first cycle button_state reads 1.
REQ-019 HELD->LONG when the hold counter (press cycle = 1) reaches LONG_CYCLES; long_press high in that LONG_CYCLES-th cycle only.
REQ-020 In LONG with repeat_en=1: repeat_pulse every REPEAT_CYCLES cycles, first one REPEAT_CYCLES cycles after the long_press cycle.
REQ-021 repeat_en=0 SHALL hold the repeat counter at 0; re-assertion SHALL restart the period from that cycle.
REQ-022 HELD or LONG ->RELEASED when button_state falls; release high exactly in the first cycle button_state reads 0; hold and repeat counters clear.
REQ-023 At most one of press, release, long_press, repeat_pulse SHALL be high in any cycle.
REQ-024 Counter widths SHALL be $clog2(param+1); hold counter SHALL saturate, never wrap, in LONG.
REQ-025 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 reset=1 SHALL force button_state, press, release, long_press, repeat_pulse to 0, FSM to RELEASED, all counters to 0 on the next edge.
REQ-027 Reset mid-hold SHALL emit no release; a level still high after reset SHALL produce a fresh press after STABLE_CYCLES samples.
REQ-028 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-029 Package button_pkg SHALL hold the FSM state typedef (RELEASED, HELD, LONG) and default parameter constants.
REQ-030 The STABLE_CYCLES filter SHALL be a sub-module named level_filter (inputs clock, reset, level_in; output level_out); the FSM and hold/repeat counters stay in button_event_decoder.

Verification (bench parameters STABLE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3)
REQ-031 Glitch: button_level high 3 cycles then low -> button_state stays 0, no pulses.
REQ-032 Clean press: level high sampled at edges 1-4 -> button_state=1 after edge 4, press high for that one cycle only.
REQ-033 Long hold, repeat_en=1: long_press in held-cycle 10; repeat_pulse in held-cycles 13, 16, 19; nothing else.
REQ-034 Release bounce: while held, low 2 / high 1 / low 4 samples -> exactly one release, after 4th low sample; button_state=0.
REQ-035 Reset in LONG with level high -> all outputs 0 next cycle, no release; press 4 cycles after reset drops.
REQ-036 Long hold with repeat_en=0, asserted at held-cycle 15 -> long_press at 10, first repeat_pulse at held-cycle 18.
